cr_tlvp2_split_core: RTL and testbench



---
 rtl/cr_tlvp2_split_core.sv | 176 +++++++++++++++++
 tb/tb_cr_tlvp2_split_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_tlvp2_split_core.sv
// TLV split core: parses an AXI4-stream frame of 64-bit words taken from a
// show-ahead ingress FIFO into TLVs. Each TLV is tagged with ordern, typen,
// sot and eot, then routed whole to the passthrough (PT) or user (USR) FIFO.
//
// ib_rdata layout (axi4s_dp_bus_t, packed):
//   [80:77] tuser, [76:73] tid, [72:65] tstrb, [64] tlast, [63:0] tdata
// pt/usr_ib_wdata layout (tlvp_if_bus_t, packed):
//   [OB_W-1:92] ordern, [91:84] typen, [83] sot, [82] eot, [81] insert,
//   [80:0] copy of the ingress word
module cr_tlvp2_split_core #(
    parameter logic [31:0] USR_TYPE_MASK      = 32'h0,
    parameter int          LEN_W              = 16,
    parameter int          TLVP_ORD_NUM_WIDTH = 4,
    localparam int         IB_W               = 81,
    localparam int         OB_W               = 92 + TLVP_ORD_NUM_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ib_empty,
    input  logic [IB_W-1:0] ib_rdata,
    output logic            ib_rd,
    input  logic            pt_ib_afull,
    output logic            pt_ib_wen,
    output logic [OB_W-1:0] pt_ib_wdata,
    input  logic            usr_ib_afull,
    output logic            usr_ib_wen,
    output logic [OB_W-1:0] usr_ib_wdata,
    output logic            bip2_err,
    output logic            len_err,
    output logic            trunc_err
);

    localparam logic [TLVP_ORD_NUM_WIDTH-1:0] ORD_ONE = TLVP_ORD_NUM_WIDTH'(1);
    localparam logic [TLVP_ORD_NUM_WIDTH-1:0] ORD_MAX = '1;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    // BIP2: bit 0 is the parity of the even bits, bit 1 of the odd bits.
    function automatic logic [1:0] calc_bip2(input logic [63:0] d);
        logic [1:0] bip;
        bip = 2'b00;
        for (int i = 0; i < 32; i++) begin
            bip[0] = bip[0] ^ d[2*i];
            bip[1] = bip[1] ^ d[2*i+1];
        end
        return bip;
    endfunction

    state_t                        state_q, state_d;
    logic [LEN_W-1:0]              rem_q, rem_d;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ord_q, ord_d;
    logic [7:0]                    typen_q, typen_d;
    logic                          dest_q, dest_d;
    logic                          pt_wen_q, pt_wen_d;
    logic                          usr_wen_q, usr_wen_d;
    logic [OB_W-1:0]               pt_wdata_q, pt_wdata_d;
    logic [OB_W-1:0]               usr_wdata_q, usr_wdata_d;
    logic                          bip2_err_q, bip2_err_d;
    logic                          len_err_q, len_err_d;
    logic                          trunc_err_q, trunc_err_d;

    logic [63:0]      word_data;
    logic             word_last;
    logic [LEN_W-1:0] hdr_len;
    logic             is_hdr;
    logic             len_zero;
    logic             len_one;
    logic             bip_bad;
    logic [7:0]       cur_typen;
    logic             cur_dest;
    logic             tlv_end;
    logic             word_eot;
    logic [OB_W-1:0]  out_word;

    // Either almost-full stalls the whole block, whichever FIFO the TLV targets.
    assign ib_rd = ~ib_empty & ~pt_ib_afull & ~usr_ib_afull;

    assign word_data = ib_rdata[63:0];
    assign word_last = ib_rdata[64];
    assign hdr_len   = word_data[8 +: LEN_W];
    assign is_hdr    = (state_q == ST_HDR);
    assign len_zero  = (hdr_len == '0);
    assign len_one   = (hdr_len <= LEN_W'(1));
    assign bip_bad   = (word_data[63:62] != calc_bip2({2'b00, word_data[61:0]}));
    assign cur_typen = is_hdr ? word_data[7:0] : typen_q;
    assign cur_dest  = is_hdr ? USR_TYPE_MASK[word_data[4:0]] : dest_q;
    // A zero-length header is handled as a single-word TLV.
    assign tlv_end   = is_hdr ? len_one : (rem_q == LEN_W'(1));
    assign word_eot  = tlv_end | word_last;
    assign out_word  = {ord_q, cur_typen, is_hdr, word_eot, 1'b0, ib_rdata};

    // Next-state: parse the popped word, tag it and pick its destination.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ord_d       = ord_q;
        typen_d     = typen_q;
        dest_d      = dest_q;
        pt_wen_d    = 1'b0;
        usr_wen_d   = 1'b0;
        pt_wdata_d  = pt_wdata_q;
        usr_wdata_d = usr_wdata_q;
        bip2_err_d  = 1'b0;
        len_err_d   = 1'b0;
        trunc_err_d = 1'b0;
        if (ib_rd) begin
            if (cur_dest) begin
                usr_wen_d   = 1'b1;
                usr_wdata_d = out_word;
            end else begin
                pt_wen_d   = 1'b1;
                pt_wdata_d = out_word;
            end
            bip2_err_d  = is_hdr & bip_bad;
            len_err_d   = is_hdr & len_zero;
            trunc_err_d = word_last & ~tlv_end;
            if (is_hdr) begin
                typen_d = word_data[7:0];
                dest_d  = USR_TYPE_MASK[word_data[4:0]];
                rem_d   = len_one ? '0 : hdr_len - LEN_W'(1);
            end else begin
                rem_d = rem_q - LEN_W'(1);
            end
            state_d = word_eot ? ST_HDR : ST_BODY;
            // Frame end restarts numbering; otherwise count TLVs, saturating.
            if (word_last) begin
                ord_d = ORD_ONE;
            end else if (tlv_end && (ord_q != ORD_MAX)) begin
                ord_d = ord_q + ORD_ONE;
            end
        end
    end

    // State and output registers; reset drops all parse context at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            rem_q       <= '0;
            ord_q       <= ORD_ONE;
            typen_q     <= '0;
            dest_q      <= 1'b0;
            pt_wen_q    <= 1'b0;
            usr_wen_q   <= 1'b0;
            pt_wdata_q  <= '0;
            usr_wdata_q <= '0;
            bip2_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ord_q       <= ord_d;
            typen_q     <= typen_d;
            dest_q      <= dest_d;
            pt_wen_q    <= pt_wen_d;
            usr_wen_q   <= usr_wen_d;
            pt_wdata_q  <= pt_wdata_d;
            usr_wdata_q <= usr_wdata_d;
            bip2_err_q  <= bip2_err_d;
            len_err_q   <= len_err_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign pt_ib_wen    = pt_wen_q;
    assign pt_ib_wdata  = pt_wdata_q;
    assign usr_ib_wen   = usr_wen_q;
    assign usr_ib_wdata = usr_wdata_q;
    assign bip2_err     = bip2_err_q;
    assign len_err      = len_err_q;
    assign trunc_err    = trunc_err_q;

endmodule

// File: tb/tb_cr_tlvp2_split_core.sv
// Directed bench for cr_tlvp2_split_core. Two instances share the ingress
// stream: one with USR_TYPE_MASK=0 (all PT) and one with USR_TYPE_MASK=4.
module tb_cr_tlvp2_split_core;

    localparam int OB_W = 96;

    typedef struct packed {
        logic        usr;
        logic [3:0]  ord;
        logic [7:0]  typ;
        logic        sot;
        logic        eot;
        logic        ins;
        logic        bip;
        logic        lenerr;
        logic        trunc;
        logic [80:0] ib;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ib_empty = 1'b1;
    logic [80:0]     ib_rdata = '0;
    logic            pt_afull = 1'b0;
    logic            usr_afull = 1'b0;

    logic            rd0, ptw0, usrw0, bip0, len0, tr0;
    logic [OB_W-1:0] ptd0, usrd0;
    logic            rd4, ptw4, usrw4, bip4, len4, tr4;
    logic [OB_W-1:0] ptd4, usrd4;

    logic [80:0]     fifo[$];
    logic [80:0]     sent[$];
    rec_t            r0[$];
    rec_t            r4[$];
    logic [18:0]     eq0[$];
    logic [18:0]     eq4[$];
    int              bip_cnt0, len_cnt0, tr_cnt0;
    int              vectors = 0;
    int              miscompares = 0;
    int              tog_cnt = 0;
    logic            tog_en = 1'b0;
    logic [OB_W-1:0] last_pt4 = '0;
    logic [OB_W-1:0] last_usr4 = '0;
    logic [37:0]     seed = 38'h15_A5A5_0001;

    always #5 clk = ~clk;

    cr_tlvp2_split_core #(
        .USR_TYPE_MASK(32'h0), .LEN_W(16), .TLVP_ORD_NUM_WIDTH(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty), .ib_rdata(ib_rdata),
        .ib_rd(rd0), .pt_ib_afull(pt_afull), .pt_ib_wen(ptw0), .pt_ib_wdata(ptd0),
        .usr_ib_afull(usr_afull), .usr_ib_wen(usrw0), .usr_ib_wdata(usrd0),
        .bip2_err(bip0), .len_err(len0), .trunc_err(tr0)
    );

    cr_tlvp2_split_core #(
        .USR_TYPE_MASK(32'h4), .LEN_W(16), .TLVP_ORD_NUM_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty), .ib_rdata(ib_rdata),
        .ib_rd(rd4), .pt_ib_afull(pt_afull), .pt_ib_wen(ptw4), .pt_ib_wdata(ptd4),
        .usr_ib_afull(usr_afull), .usr_ib_wen(usrw4), .usr_ib_wdata(usrd4),
        .bip2_err(bip4), .len_err(len4), .trunc_err(tr4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] typ, input logic [15:0] len,
                                           input logic [37:0] pay);
        logic [63:0] d;
        logic        b_even, b_odd;
        d      = {2'b00, pay, len, typ};
        b_even = ^(d & 64'h5555_5555_5555_5555);
        b_odd  = ^(d & 64'hAAAA_AAAA_AAAA_AAAA);
        d[63]  = b_odd;
        d[62]  = b_even;
        return d;
    endfunction

    function automatic logic [80:0] mk_ib(input logic [63:0] d, input logic last);
        return {d[7:4], d[3:0], 8'hFF, last, d};
    endfunction

    function automatic rec_t dec(input logic [OB_W-1:0] w, input logic usr,
                                 input logic b, input logic l, input logic t);
        rec_t r;
        r.usr = usr;  r.ord = w[95:92]; r.typ = w[91:84]; r.sot = w[83];
        r.eot = w[82]; r.ins = w[81]; r.ib = w[80:0];
        r.bip = b; r.lenerr = l; r.trunc = t;
        return r;
    endfunction

    task automatic ph(input int typ, input int len, input logic last, input logic corrupt);
        logic [63:0] d;
        d = mk_hdr(8'(typ), 16'(len), seed);
        if (corrupt) d[62] = ~d[62];
        seed = seed * 38'd5 + 38'd3;
        fifo.push_back(mk_ib(d, last));
    endtask

    task automatic pb(input logic last);
        fifo.push_back(mk_ib({26'h2C0FFEE, seed}, last));
        seed = seed * 38'd5 + 38'd7;
    endtask

    task automatic exp_w(input logic u4, input int ord, input int typ, input logic sot,
                         input logic eot, input logic b, input logic l, input logic t);
        eq0.push_back({1'b0, 4'(ord), 8'(typ), sot, eot, 1'b0, b, l, t});
        eq4.push_back({u4, 4'(ord), 8'(typ), sot, eot, 1'b0, b, l, t});
    endtask

    // One clock cycle: present the FIFO head, pop on ib_rd, record writes.
    task automatic step();
        logic rd;
        @(negedge clk);
        if (tog_en) begin
            pt_afull  = tog_cnt[1];
            usr_afull = ((tog_cnt % 5) == 4);
            tog_cnt++;
        end
        ib_empty = (fifo.size() == 0);
        ib_rdata = ib_empty ? '0 : fifo[0];
        #1;
        rd = ~ib_empty & ~pt_afull & ~usr_afull;
        chk("ib_rd", 128'({rd0, rd4}), 128'({rd, rd}));
        @(posedge clk);
        if (rd) sent.push_back(fifo.pop_front());
        #1;
        chk("wen_lat0", 128'(ptw0 | usrw0), 128'(rd));
        chk("wen_lat4", 128'(ptw4 | usrw4), 128'(rd));
        chk("both_wen4", 128'(ptw4 & usrw4), 128'(0));
        if (ptw0)  r0.push_back(dec(ptd0, 1'b0, bip0, len0, tr0));
        if (usrw0) r0.push_back(dec(usrd0, 1'b1, bip0, len0, tr0));
        if (ptw4)  r4.push_back(dec(ptd4, 1'b0, bip4, len4, tr4));
        if (usrw4) r4.push_back(dec(usrd4, 1'b1, bip4, len4, tr4));
        if (bip0) bip_cnt0++;
        if (len0) len_cnt0++;
        if (tr0)  tr_cnt0++;
        if (ptw4) last_pt4 = ptd4;
        else chk("pt_hold4", 128'(ptd4), 128'(last_pt4));
        if (usrw4) last_usr4 = usrd4;
        else chk("usr_hold4", 128'(usrd4), 128'(last_usr4));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 128'(fifo.size()), 128'(0));
        step();
    endtask

    task automatic compare(input string tag);
        int eb, el, et;
        chk({tag, "_n0"}, 128'(r0.size()), 128'(eq0.size()));
        chk({tag, "_n4"}, 128'(r4.size()), 128'(eq4.size()));
        eb = 0; el = 0; et = 0;
        for (int i = 0; i < eq0.size(); i++) begin
            eb += int'(eq0[i][2]); el += int'(eq0[i][1]); et += int'(eq0[i][0]);
        end
        for (int i = 0; i < r0.size() && i < eq0.size() && i < sent.size(); i++) begin
            $display("[%s] dut0 w%0d meta=%05h ib=%021h", tag, i,
                     {r0[i].usr, r0[i].ord, r0[i].typ, r0[i].sot, r0[i].eot, r0[i].ins,
                      r0[i].bip, r0[i].lenerr, r0[i].trunc}, r0[i].ib);
            chk($sformatf("%s_meta0[%0d]", tag, i),
                128'({r0[i].usr, r0[i].ord, r0[i].typ, r0[i].sot, r0[i].eot, r0[i].ins,
                      r0[i].bip, r0[i].lenerr, r0[i].trunc}), 128'(eq0[i]));
            chk($sformatf("%s_ib0[%0d]", tag, i), 128'(r0[i].ib), 128'(sent[i]));
        end
        for (int i = 0; i < r4.size() && i < eq4.size() && i < sent.size(); i++) begin
            $display("[%s] dut4 w%0d usr=%0d ord=%0d sot=%0d eot=%0d", tag, i,
                     r4[i].usr, r4[i].ord, r4[i].sot, r4[i].eot);
            chk($sformatf("%s_meta4[%0d]", tag, i),
                128'({r4[i].usr, r4[i].ord, r4[i].typ, r4[i].sot, r4[i].eot, r4[i].ins,
                      r4[i].bip, r4[i].lenerr, r4[i].trunc}), 128'(eq4[i]));
            chk($sformatf("%s_ib4[%0d]", tag, i), 128'(r4[i].ib), 128'(sent[i]));
        end
        chk({tag, "_bip_pulses"},   128'(bip_cnt0), 128'(eb));
        chk({tag, "_len_pulses"},   128'(len_cnt0), 128'(el));
        chk({tag, "_trunc_pulses"}, 128'(tr_cnt0),  128'(et));
        r0.delete(); r4.delete(); eq0.delete(); eq4.delete(); sent.delete();
        bip_cnt0 = 0; len_cnt0 = 0; tr_cnt0 = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 128'({rd0, ptw0, usrw0, bip0, len0, tr0,
                                  rd4, ptw4, usrw4, bip4, len4, tr4}), 128'(0));
        chk({tag, "_ptd0"},  128'(ptd0),  128'(0));
        chk({tag, "_usrd0"}, 128'(usrd0), 128'(0));
        chk({tag, "_ptd4"},  128'(ptd4),  128'(0));
        chk({tag, "_usrd4"}, 128'(usrd4), 128'(0));
    endtask

    initial begin
        bip_cnt0 = 0; len_cnt0 = 0; tr_cnt0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Three TLVs, typen 1/2/3, len 1/3/2, tlast on the last word.
        ph(1, 1, 1'b0, 1'b0); ph(2, 3, 1'b0, 1'b0); pb(1'b0); pb(1'b0);
        ph(3, 2, 1'b0, 1'b0); pb(1'b1);
        drain();
        exp_w(1'b0, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("frame3");

        // Header with a corrupted BIP2 bit, forwarded unchanged.
        ph(4, 1, 1'b1, 1'b1);
        drain();
        exp_w(1'b0, 1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("bip");

        // len=4 truncated by tlast on word 2, then a new single-word frame.
        ph(6, 4, 1'b0, 1'b0); pb(1'b1); ph(7, 1, 1'b1, 1'b0);
        drain();
        exp_w(1'b0, 1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 1, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_w(1'b0, 1, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("trunc");

        // len=0 header; typen 34 indexes mask bit 2; len=0 plus bad BIP2 with tlast.
        ph(8, 0, 1'b0, 1'b0); ph(34, 1, 1'b0, 1'b0); ph(11, 0, 1'b1, 1'b1);
        drain();
        exp_w(1'b0, 1, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_w(1'b1, 2, 34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 3, 11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        compare("len0");

        // 17 single-word TLVs: ordern saturates at 15.
        for (int i = 0; i < 17; i++) begin
            ph(10, 1, (i == 16), 1'b0);
            exp_w(1'b0, (i < 15) ? i + 1 : 15, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drain();
        compare("sat");

        // 5-word USR TLV under toggling back-pressure.
        tog_en = 1'b1;
        ph(2, 5, 1'b0, 1'b0); pb(1'b0); pb(1'b0); pb(1'b0); pb(1'b1);
        drain();
        tog_en = 1'b0; pt_afull = 1'b0; usr_afull = 1'b0;
        exp_w(1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) exp_w(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("bp");

        // Reset after 3 of 5 words; the next word parses as a fresh header.
        tog_en = 1'b1;
        ph(2, 5, 1'b0, 1'b0); pb(1'b0); pb(1'b0);
        drain();
        tog_en = 1'b0; pt_afull = 1'b0; usr_afull = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_pt4 = '0; last_usr4 = '0;
        ph(3, 2, 1'b0, 1'b0); pb(1'b1);
        drain();
        exp_w(1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_w(1'b0, 1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
